// File: rtl/grayscale_if.sv
// Pixel-stream handshake bundle between the RGB FIFO, the grayscale converter and the gray FIFO.
// master is the converter side; slave is the FIFO/environment side.
interface grayscale_if;
  logic        rgb_rd_en;
  logic        rgb_empty;
  logic [23:0] rgb_dout;
  logic        gray_wr_en;
  logic        gray_full;
  logic [7:0]  gray_din;
  logic        done;

  modport master (
    output rgb_rd_en,
    input  rgb_empty,
    input  rgb_dout,
    output gray_wr_en,
    input  gray_full,
    output gray_din,
    output done
  );

  modport slave (
    input  rgb_rd_en,
    output rgb_empty,
    output rgb_dout,
    input  gray_wr_en,
    output gray_full,
    input  gray_din,
    input  done
  );
endinterface

// File: rtl/grayscale.sv
// RGB-to-gray converter: two-stage pipeline (sum, then divide by 3) between FWFT RGB FIFO and
// gray FIFO, with full backpressure and a per-frame push counter that pulses done.
module grayscale #(
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540
) (
  input  logic         clock,
  input  logic         reset,
  grayscale_if.master  bus
);

  localparam int unsigned FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned CNT_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);
  // 683/2048 overshoots 1/3 by < 0.125/765 per unit; floor stays exact for sums 0..765.
  localparam logic [19:0] RECIP3 = 20'd683;

  logic [9:0]       sum_a;
  logic             valid_a;
  logic [7:0]       gray_b;
  logic             valid_b;
  logic [CNT_W-1:0] pix_cnt;
  logic             done_q;

  logic       wr_en;
  logic       rd_en;
  logic       b_free;
  logic       a_move;
  logic       a_free;
  logic [9:0] rgb_sum;
  logic [19:0] prod;
  logic [7:0] quot;
  logic       unused_prod;

  always_comb begin
    wr_en   = valid_b && !bus.gray_full;
    b_free  = !valid_b || wr_en;
    a_move  = valid_a && b_free;
    a_free  = !valid_a || a_move;
    // Gated by reset so no pixel is popped and then discarded while held in reset.
    rd_en   = reset && !bus.rgb_empty && a_free;
    rgb_sum = 10'(bus.rgb_dout[23:16]) + 10'(bus.rgb_dout[15:8]) + 10'(bus.rgb_dout[7:0]);
    prod    = 20'(sum_a) * RECIP3;
    quot    = prod[18:11];
  end

  assign unused_prod = ^{prod[19], prod[10:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_a   <= '0;
      valid_a <= 1'b0;
      gray_b  <= '0;
      valid_b <= 1'b0;
      pix_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      if (rd_en) begin
        sum_a   <= rgb_sum;
        valid_a <= 1'b1;
      end else if (a_move) begin
        valid_a <= 1'b0;
      end

      if (a_move) begin
        gray_b  <= quot;
        valid_b <= 1'b1;
      end else if (wr_en) begin
        valid_b <= 1'b0;
      end

      done_q <= 1'b0;
      if (wr_en) begin
        if (pix_cnt == LAST_PIX) begin
          pix_cnt <= '0;
          done_q  <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.rgb_rd_en  = rd_en;
  assign bus.gray_wr_en = wr_en;
  assign bus.gray_din   = valid_b ? gray_b : 8'd0;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_grayscale.sv
// Self-checking bench for grayscale: FWFT source queue, expected-gray queue model with frame
// done tracking, checked every cycle on the falling edge.
module tb_grayscale;
  localparam int unsigned W     = 4;
  localparam int unsigned H     = 2;
  localparam int unsigned FRAME = W * H;

  logic clock = 1'b0;
  logic reset = 1'b1;

  grayscale_if bus();

  grayscale #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [23:0] src_q[$];
  logic [7:0]  exp_q[$];
  int cyc = 0;
  int push_cnt = 0;
  int push_total = 0;
  int pop_total = 0;
  int done_total = 0;
  bit done_pend = 1'b0;
  bit rd_seen = 1'b0;
  int full_mode = 0;
  bit gap_mode = 1'b0;
  int last_rd_cyc = -1;
  int last_wr_cyc = -1;
  logic [7:0] last_din = 8'd0;

  function automatic logic [7:0] gray_of(logic [23:0] p);
    int s;
    s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    return 8'(s / 3);
  endfunction

  task automatic chk(string name, longint act, longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic drive_inputs();
    bit gap;
    gap = gap_mode ? bit'($urandom_range(0, 1)) : 1'b0;
    case (full_mode)
      1:       bus.gray_full = (cyc % 5) < 3;
      2:       bus.gray_full = 1'b1;
      default: bus.gray_full = 1'b0;
    endcase
    bus.rgb_empty = (src_q.size() == 0) || gap;
    bus.rgb_dout  = (src_q.size() != 0) ? src_q[0] : 24'h0;
  endtask

  task automatic monitor();
    bit exp_done;
    exp_done  = done_pend;
    done_pend = 1'b0;
    chk("done", bus.done, exp_done);
    if (bus.done) done_total++;
    if (!reset) begin
      chk("rst_rd_en", bus.rgb_rd_en, 0);
      chk("rst_wr_en", bus.gray_wr_en, 0);
      chk("rst_din", bus.gray_din, 0);
    end else begin
      if (bus.gray_wr_en) begin
        chk("wr_while_full", bus.gray_full, 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_push: got gray_din %0d expected no push (cycle %0d)",
                   bus.gray_din, cyc);
        end else begin
          chk("gray_din", bus.gray_din, exp_q.pop_front());
        end
        push_cnt++;
        push_total++;
        last_wr_cyc = cyc;
        last_din    = bus.gray_din;
        if (push_cnt % FRAME == 0) done_pend = 1'b1;
      end
      if (bus.rgb_rd_en) begin
        chk("rd_while_empty", bus.rgb_empty, 0);
        if (src_q.size() != 0) exp_q.push_back(gray_of(src_q[0]));
        pop_total++;
        last_rd_cyc = cyc;
      end
    end
    rd_seen = bus.rgb_rd_en;
  endtask

  task automatic step();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    if (rd_seen && src_q.size() != 0) void'(src_q.pop_front());
    cyc++;
    drive_inputs();
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (src_q.size() != 0 || exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d src and %0d expected left, required 0",
               src_q.size(), exp_q.size());
    end
    step();
    step();
  endtask

  task automatic clear_model();
    src_q.delete();
    exp_q.delete();
    push_cnt  = 0;
    done_pend = 1'b0;
    rd_seen   = 1'b0;
  endtask

  logic [23:0] singles[5]    = '{24'hFFFFFF, 24'h0A141F, 24'h010100, 24'h000002, 24'h000003};
  logic [7:0]  single_exp[5] = '{8'd255, 8'd20, 8'd0, 8'd0, 8'd1};

  initial begin
    int p0;
    int q0;
    int d0;
    int r;
    int g;

    bus.rgb_empty = 1'b1;
    bus.rgb_dout  = 24'h0;
    bus.gray_full = 1'b0;

    // Power-on reset, checked asynchronously before any clock edge matters.
    #3 reset = 1'b0;
    #1;
    chk("por_rd_en", bus.rgb_rd_en, 0);
    chk("por_wr_en", bus.gray_wr_en, 0);
    chk("por_din", bus.gray_din, 0);
    chk("por_done", bus.done, 0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    drive_inputs();

    // Single pixels: latency and hand-computed values.
    for (int i = 0; i < 5; i++) begin
      chk("model_pin", gray_of(singles[i]), single_exp[i]);
      src_q.push_back(singles[i]);
      drive_inputs();
      drain(20);
      chk("single_latency", last_wr_cyc - last_rd_cyc, 2);
      chk("single_value", last_din, single_exp[i]);
    end
    chk("model_pin_510", gray_of(24'hFFFF00), 170);
    chk("model_pin_764", gray_of(24'hFFFEFF), 254);

    // Every sum 0..765 back-to-back; also checks 1 pixel/cycle throughput.
    for (int s = 0; s <= 765; s++) begin
      r = (s > 255) ? 255 : s;
      g = ((s - r) > 255) ? 255 : (s - r);
      src_q.push_back({8'(r), 8'(g), 8'(s - r - g)});
    end
    drive_inputs();
    p0 = pop_total;
    repeat (766) step();
    chk("throughput_pops", pop_total - p0, 766);
    drain(50);

    // Full stall: only two pixels may enter, then popping stops.
    full_mode = 2;
    for (int i = 0; i < 16; i++) src_q.push_back({8'(i * 16), 8'(i * 7 + 3), 8'(255 - i * 9)});
    drive_inputs();
    p0 = pop_total;
    repeat (6) step();
    chk("stall_pops", pop_total - p0, 2);
    chk("stall_rd_en", bus.rgb_rd_en, 0);
    full_mode = 1;
    drain(200);
    full_mode = 0;

    // Frame done: 20 pixels from a fresh count give exactly two pulses.
    reset = 1'b0;
    clear_model();
    #2 reset = 1'b1;
    d0 = done_total;
    for (int i = 0; i < 20; i++) src_q.push_back({8'(i), 8'(i * 3), 8'(200 - i)});
    drive_inputs();
    drain(60);
    chk("frame_dones", done_total - d0, 2);

    // Random upstream gaps.
    gap_mode = 1'b1;
    q0 = push_total;
    for (int i = 0; i < 40; i++) src_q.push_back({8'(i * 5), 8'(i * 11), 8'(i * 13)});
    drive_inputs();
    drain(400);
    chk("gap_count", push_total - q0, 40);
    gap_mode = 1'b0;

    // Asynchronous reset with both stages full and moving.
    for (int i = 0; i < 20; i++) src_q.push_back(24'h303030);
    drive_inputs();
    repeat (3) step();
    chk("pre_reset_rd_en", bus.rgb_rd_en, 1);
    chk("pre_reset_wr_en", bus.gray_wr_en, 1);
    chk("pre_reset_din", bus.gray_din, 48);
    #2 reset = 1'b0;
    #1;
    chk("async_rd_en", bus.rgb_rd_en, 0);
    chk("async_wr_en", bus.gray_wr_en, 0);
    chk("async_din", bus.gray_din, 0);
    chk("async_done", bus.done, 0);
    clear_model();
    for (int i = 0; i < 8; i++) src_q.push_back({8'(i * 30), 8'(90), 8'(255 - i)});
    drive_inputs();
    repeat (2) step();
    #1 reset = 1'b1;
    d0 = done_total;
    q0 = push_total;
    drain(40);
    chk("post_reset_pushes", push_total - q0, 8);
    chk("post_reset_dones", done_total - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
